inference_sequencer: RTL

// - Sequences one full inference on the Neuro-Edge accelerator: pixel load -> N timesteps of
//   (spike encode -> crossbar VMM -> accumulate) -> done.
// - Arbitrates the crossbar weight-write port between the host and the active inference.
// - Sits between top_neuro_edge control inputs and the encoder / crossbar_controller / accumulator.

---
 rtl/inference_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Sequences one inference on the Neuro-Edge accelerator:
//   pixel LOAD -> n_steps x (ENC -> VMM -> ACC) -> FINISH, and arbitrates the
//   crossbar weight-write port between the host and the running inference.
//
//   Optional feature macro: NEURO_SEQ_WATCHDOG_EN
//     defined   : ENC/VMM watchdog with TIMEOUT-cycle limit, ERROR state, err flag
//     undefined : ENC/VMM wait forever, err tied low
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         inference request / cancel
//   n_steps              timestep count, latched when leaving IDLE (0 runs as 1)
//   pixel_valid          host pixel strobe
//   pixel_ready          high while in LOAD
//   pix_we, pix_addr     pixel write strobe (combinational) and pixel index
//   host_wreq, host_wgnt host weight-write request / grant (grant is combinational)
//   enc_start, enc_done  encoder kick / completion
//   vmm_start, vmm_done  crossbar VMM kick / completion
//   acc_clr, acc_en      accumulator clear / accumulate strobes
//   step_idx             current timestep
//   busy, done, err      status: active, completion pulse, watchdog error
module inference_sequencer #(
    parameter int N_INPUTS = 784,
    parameter int STEP_W   = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [STEP_W-1:0]           n_steps,
    input  logic                        pixel_valid,
    output logic                        pixel_ready,
    output logic                        pix_we,
    output logic [$clog2(N_INPUTS)-1:0] pix_addr,
    input  logic                        host_wreq,
    output logic                        host_wgnt,
    output logic                        enc_start,
    input  logic                        enc_done,
    output logic                        vmm_start,
    input  logic                        vmm_done,
    output logic                        acc_clr,
    output logic                        acc_en,
    output logic [STEP_W-1:0]           step_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int PIX_W = $clog2(N_INPUTS);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENC,
        VMM,
        ACC,
        FINISH
`ifdef NEURO_SEQ_WATCHDOG_EN
        , ERROR
`endif
    } state_t;

    state_t              state, state_nx;
    logic                start_pend, start_pend_nx;
    logic [STEP_W-1:0]   n_lat, n_lat_nx;
    logic [STEP_W-1:0]   step_nx;
    logic [PIX_W-1:0]    pix_nx;
    logic                enc_start_nx, vmm_start_nx, acc_clr_nx, acc_en_nx, done_nx;
    logic                in_idle_like;

`ifdef NEURO_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_expired;

    assign wd_expired   = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign in_idle_like = (state == IDLE) || (state == ERROR);
`else
    assign in_idle_like = (state == IDLE);
`endif

    assign pix_we    = pixel_valid & pixel_ready;
    assign host_wgnt = host_wreq & in_idle_like;

    always_comb begin
        state_nx      = state;
        start_pend_nx = start_pend;
        n_lat_nx      = n_lat;
        step_nx       = step_idx;
        pix_nx        = pix_addr;
        enc_start_nx  = 1'b0;
        vmm_start_nx  = 1'b0;
        acc_clr_nx    = 1'b0;
        acc_en_nx     = 1'b0;
        done_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (abort) begin
                    start_pend_nx = 1'b0;
                end else if (start_pend && !host_wreq) begin
                    state_nx      = LOAD;
                    start_pend_nx = 1'b0;
                    n_lat_nx      = (n_steps == '0) ? STEP_W'(1) : n_steps;
                    step_nx       = '0;
                    pix_nx        = '0;
                    acc_clr_nx    = 1'b1;
                end else if (start) begin
                    start_pend_nx = 1'b1;
                end
            end
            LOAD: begin
                if (pix_we) begin
                    if (pix_addr == PIX_LAST) begin
                        state_nx     = ENC;
                        enc_start_nx = 1'b1;
                    end else begin
                        pix_nx = pix_addr + 1'b1;
                    end
                end
            end
            // The kick register is high exactly on the entry cycle, so it
            // doubles as the "ignore done this cycle" qualifier.
            ENC: begin
                if (!enc_start && enc_done) begin
                    state_nx     = VMM;
                    vmm_start_nx = 1'b1;
                end
`ifdef NEURO_SEQ_WATCHDOG_EN
                else if (wd_expired) begin
                    state_nx = ERROR;
                end
`endif
            end
            VMM: begin
                if (!vmm_start && vmm_done) begin
                    state_nx  = ACC;
                    acc_en_nx = 1'b1;
                end
`ifdef NEURO_SEQ_WATCHDOG_EN
                else if (wd_expired) begin
                    state_nx = ERROR;
                end
`endif
            end
            ACC: begin
                if (step_idx == n_lat - 1'b1) begin
                    state_nx = FINISH;
                    done_nx  = 1'b1;
                end else begin
                    step_nx      = step_idx + 1'b1;
                    state_nx     = ENC;
                    enc_start_nx = 1'b1;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = state;
            end
        endcase

        // abort outranks every other event outside IDLE
        if (abort && state != IDLE) begin
            state_nx      = IDLE;
            start_pend_nx = 1'b0;
            step_nx       = '0;
            pix_nx        = '0;
            enc_start_nx  = 1'b0;
            vmm_start_nx  = 1'b0;
            acc_clr_nx    = 1'b0;
            acc_en_nx     = 1'b0;
            done_nx       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_pend  <= 1'b0;
            n_lat       <= '0;
            step_idx    <= '0;
            pix_addr    <= '0;
            enc_start   <= 1'b0;
            vmm_start   <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            done        <= 1'b0;
            pixel_ready <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            start_pend  <= start_pend_nx;
            n_lat       <= n_lat_nx;
            step_idx    <= step_nx;
            pix_addr    <= pix_nx;
            enc_start   <= enc_start_nx;
            vmm_start   <= vmm_start_nx;
            acc_clr     <= acc_clr_nx;
            acc_en      <= acc_en_nx;
            done        <= done_nx;
            pixel_ready <= (state_nx == LOAD);
`ifdef NEURO_SEQ_WATCHDOG_EN
            busy        <= (state_nx != IDLE) && (state_nx != ERROR);
            err         <= (state_nx == ERROR);
`else
            busy        <= (state_nx != IDLE);
            err         <= 1'b0;
`endif
        end
    end

`ifdef NEURO_SEQ_WATCHDOG_EN
    // Restarts on every state entry, counts only while waiting in ENC/VMM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state_nx != state || !(state == ENC || state == VMM)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`endif

endmodule
